// File: rtl/dft8_stream.sv
// dft8_stream: streaming 8-point radix-2 DIT FFT with valid/ready input and output.
// A frame is loaded bit-reversed, transformed in place over three cycles, then drained in natural order.
module dft8_stream #(
  parameter int DW   = 8,
  parameter int FRAC = 4,
  parameter int TWF  = 7,
  parameter int OW   = DW + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic [2:0]           out_idx,
  output logic                 out_last
);

  if (OW < DW + 3 || TWF < 4 || TWF > 15 || FRAC < 0 || FRAC > DW) begin : g_bad_params
    $error("dft8_stream: illegal parameter combination");
  end

  typedef enum logic [2:0] {LOAD, STAGE1, STAGE2, STAGE3, OUT} state_t;

  localparam int PW = OW + TWF + 1;

  // round(0.70710678 * 2^f) for the supported twiddle precisions
  function automatic int twiddle_c(input int f);
    case (f)
      4:       return 11;
      5:       return 23;
      6:       return 45;
      7:       return 91;
      8:       return 181;
      9:       return 362;
      10:      return 724;
      11:      return 1448;
      12:      return 2896;
      13:      return 5793;
      14:      return 11585;
      default: return 23170;
    endcase
  endfunction

  localparam logic signed [PW-1:0] C_W  = PW'(twiddle_c(TWF));
  localparam logic signed [PW-1:0] HALF = PW'(1) << (TWF - 1);

  function automatic logic signed [PW-1:0] sx(input logic signed [OW-1:0] v);
    return {{(PW - OW){v[OW-1]}}, v};
  endfunction

  function automatic logic signed [OW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = (p + HALF) >>> TWF;
    return s[OW-1:0];
  endfunction

  function automatic logic [2:0] bitrev(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic inv_q, inv_d;
  logic signed [OW-1:0] re_q [8];
  logic signed [OW-1:0] re_d [8];
  logic signed [OW-1:0] im_q [8];
  logic signed [OW-1:0] im_d [8];
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic signed [OW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [2:0] out_idx_q, out_idx_d, nxt_idx;
  logic out_last_q, out_last_d;

  int lg;
  logic [2:0] a_i, b_i;
  logic [1:0] tw;
  logic signed [OW-1:0] br, bi, tr, ti;
  logic signed [PW-1:0] wr, wi;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inv_d       = inv_q;
    re_d        = re_q;
    im_d        = im_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    nxt_idx     = out_idx_q + 3'd1;
    lg          = 0;
    a_i         = '0;
    b_i         = '0;
    tw          = '0;
    br          = '0;
    bi          = '0;
    tr          = '0;
    ti          = '0;
    wr          = '0;
    wi          = '0;

    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          re_d[bitrev(cnt_q)] = {{(OW - DW){in_data[DW-1]}}, in_data};
          im_d[bitrev(cnt_q)] = '0;
          if (cnt_q == 3'd0) inv_d = inv;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d    = STAGE1;
            in_ready_d = 1'b0;
          end
        end
      end

      STAGE1, STAGE2, STAGE3: begin
        lg = (state_q == STAGE1) ? 0 : (state_q == STAGE2) ? 1 : 2;
        // span is 1<<lg; twiddle exponent is the position inside the group scaled up to W8
        for (int i = 0; i < 8; i++) begin
          if (((i >> lg) & 1) == 0) begin
            a_i = 3'(i);
            b_i = 3'(i + (1 << lg));
            tw  = 2'((i & ((1 << lg) - 1)) << (2 - lg));
            br  = re_q[b_i];
            bi  = im_q[b_i];
            case (tw)
              2'd0: begin
                tr = br;
                ti = bi;
              end
              2'd2: begin
                tr = inv_q ? -bi : bi;
                ti = inv_q ? br : -br;
              end
              default: begin
                wr = (tw == 2'd1) ? C_W : -C_W;
                wi = inv_q ? C_W : -C_W;
                tr = round_shift(wr * sx(br) - wi * sx(bi));
                ti = round_shift(wr * sx(bi) + wi * sx(br));
              end
            endcase
            re_d[a_i] = re_q[a_i] + tr;
            im_d[a_i] = im_q[a_i] + ti;
            re_d[b_i] = re_q[a_i] - tr;
            im_d[b_i] = im_q[a_i] - ti;
          end
        end
        state_d = (state_q == STAGE1) ? STAGE2 : (state_q == STAGE2) ? STAGE3 : OUT;
      end

      OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_re_d    = re_q[0];
          out_im_d    = im_q[0];
          out_idx_d   = 3'd0;
          out_last_d  = 1'b0;
        end else if (out_ready) begin
          if (out_idx_q == 3'd7) begin
            out_valid_d = 1'b0;
            out_re_d    = '0;
            out_im_d    = '0;
            out_idx_d   = 3'd0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = LOAD;
          end else begin
            out_re_d   = re_q[nxt_idx];
            out_im_d   = im_q[nxt_idx];
            out_idx_d  = nxt_idx;
            out_last_d = (nxt_idx == 3'd7);
          end
        end
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      re_q        <= re_d;
      im_q        <= im_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dft8_stream.sv
// tb_dft8_stream: scoreboard bench for dft8_stream; expected bins come from a
// size-2 / size-4 / size-8 DFT decomposition model with the same twiddle rounding.
`timescale 1ns/1ps
module tb_dft8_stream;
  localparam int DW   = 8;
  localparam int OW   = DW + 3;
  localparam int TWF  = 7;
  localparam int C    = 91;
  localparam int HALF = 1 << (TWF - 1);

  typedef struct {
    int re;
    int im;
    int idx;
  } bin_t;

  logic clk, rst, in_valid, in_ready, inv, out_valid, out_ready, out_last;
  logic [DW-1:0] in_data;
  logic signed [OW-1:0] out_re, out_im;
  logic [2:0] out_idx;

  int checks = 0;
  int failures = 0;
  bin_t exp_q[$];
  int bins_done = 0;
  int ready_mode = 0;
  bit stall_done = 0;
  bit full_speed = 0;
  bit xfer_seen = 0;
  time last_xfer_time = 0;

  dft8_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inv(inv), .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
    .out_im(out_im), .out_idx(out_idx), .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // W8^k applied to (br,bi); conjugated twiddle in inverse mode
  task automatic tw_mul(input int k, input int br, input int bi, input bit iv,
                        output int tr, output int ti);
    int s;
    longint wr, wi, pr, pim;
    s = iv ? 1 : -1;
    if (k == 0) begin
      tr = br;
      ti = bi;
    end else if (k == 2) begin
      tr = -s * bi;
      ti = s * br;
    end else begin
      wr  = (k == 1) ? C : -C;
      wi  = s * C;
      pr  = wr * br - wi * bi + HALF;
      pim = wr * bi + wi * br + HALF;
      tr  = int'(pr >>> TWF);
      ti  = int'(pim >>> TWF);
    end
  endtask

  task automatic model_frame(input int x[8], input bit iv);
    int a_re[4][2], a_im[4][2], b_re[2][4], b_im[2][4];
    int tr, ti;
    bin_t e;
    for (int o = 0; o < 4; o++) begin
      a_re[o][0] = x[o] + x[o+4];
      a_re[o][1] = x[o] - x[o+4];
      a_im[o][0] = 0;
      a_im[o][1] = 0;
    end
    for (int o = 0; o < 2; o++) begin
      for (int k = 0; k < 2; k++) begin
        tw_mul(2 * k, a_re[o+2][k], a_im[o+2][k], iv, tr, ti);
        b_re[o][k]   = a_re[o][k] + tr;
        b_im[o][k]   = a_im[o][k] + ti;
        b_re[o][k+2] = a_re[o][k] - tr;
        b_im[o][k+2] = a_im[o][k] - ti;
      end
    end
    for (int k = 0; k < 8; k++) begin
      tw_mul(k % 4, b_re[1][k%4], b_im[1][k%4], iv, tr, ti);
      e.idx = k;
      e.re  = (k < 4) ? b_re[0][k%4] + tr : b_re[0][k%4] - tr;
      e.im  = (k < 4) ? b_im[0][k%4] + ti : b_im[0][k%4] - ti;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_sample(input int d, input bit iv);
    int waited;
    waited = 0;
    in_data  = d[DW-1:0];
    inv      = iv;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check_output("in_ready_wait", int'(in_ready), 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input int x[8], input bit iv, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_sample(x[i], (i == 0) ? iv : 1'($urandom_range(0, 1)));
    end
    last_xfer_time = $time - 1;
    xfer_seen = 1'b1;
    model_frame(x, iv);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_in_ready", int'(in_ready), 1);
    check_output("rst_out_last", int'(out_last), 0);
    check_output("rst_out_idx", int'(out_idx), 0);
    check_output("rst_out_re", int'(out_re), 0);
    check_output("rst_out_im", int'(out_im), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check_output("scoreboard_drained", exp_q.size(), 0);
  endtask

  // downstream ready: always, random, or a single 5-cycle stall on bin 3
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else if (out_valid && out_idx == 3'd3 && !stall_done) begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        stall_done = 1'b1;
      end else out_ready = 1'b1;
    end
  end

  int low_cnt = 0;
  bit prev_valid = 0;
  bin_t e_mon;

  always @(negedge clk) begin
    if (rst) begin
      low_cnt = 0;
      prev_valid = 0;
    end else begin
      if (!in_ready) low_cnt++;
      else begin
        if (low_cnt > 0 && full_speed) check_output("in_ready_low_cycles", low_cnt, 12);
        low_cnt = 0;
      end
      if (out_valid && !prev_valid && xfer_seen)
        check_output("first_bin_latency_ns", int'($time - last_xfer_time), 45);
      if (out_valid) begin
        if (exp_q.size() == 0) check_output("out_valid_without_frame", int'(out_valid), 0);
        else begin
          e_mon = exp_q[0];
          check_output("bin_re", int'(out_re), e_mon.re);
          check_output("bin_im", int'(out_im), e_mon.im);
          check_output("bin_idx", int'(out_idx), e_mon.idx);
          check_output("bin_last", int'(out_last), (e_mon.idx == 7) ? 1 : 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            bins_done++;
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fr[8];
    int target;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    inv = 1'b0;
    #1;
    pulse_reset();

    full_speed = 1'b1;
    fr = '{16, 0, 0, 0, 0, 0, 0, 0};
    apply_stimulus(fr, 1'b0, 1'b0);
    fr = '{16, 16, 16, 16, 16, 16, 16, 16};
    apply_stimulus(fr, 1'b0, 1'b0);
    fr = '{16, -16, 16, -16, 16, -16, 16, -16};
    apply_stimulus(fr, 1'b0, 1'b0);
    fr = '{0, 16, 0, 0, 0, 0, 0, 0};
    apply_stimulus(fr, 1'b0, 1'b0);
    apply_stimulus(fr, 1'b1, 1'b0);
    fr = '{-128, -128, -128, -128, -128, -128, -128, -128};
    apply_stimulus(fr, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) fr[i] = int'($urandom_range(0, 255)) - 128;
    apply_stimulus(fr, 1'($urandom_range(0, 1)), 1'b0);
    full_speed = 1'b0;
    stall_done = 1'b0;
    ready_mode = 2;
    wait_drain();

    ready_mode = 1;
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = int'($urandom_range(0, 255)) - 128;
      apply_stimulus(fr, 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain();
    ready_mode = 0;

    for (int i = 0; i < 3; i++) send_sample(int'($urandom_range(0, 255)) - 128, 1'b1);
    pulse_reset();
    fr = '{16, 0, 0, 0, 0, 0, 0, 0};
    apply_stimulus(fr, 1'b0, 1'b0);
    wait_drain();

    for (int i = 0; i < 8; i++) fr[i] = int'($urandom_range(0, 255)) - 128;
    target = bins_done + 3;
    apply_stimulus(fr, 1'b0, 1'b0);
    for (int n = 0; n < 100 && bins_done < target; n++) @(posedge clk);
    if (bins_done < target) check_output("bin2_wait", bins_done, target);
    #1;
    pulse_reset();
    fr = '{16, 0, 0, 0, 0, 0, 0, 0};
    apply_stimulus(fr, 1'b0, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
